// File: rtl/tim_cfg_seq_if.sv
// APB link between the configuration sequencer and the timer slave port.
//  master: drives timx_psel/penable/pwrite/paddr/pwdata, samples timx_prdata
//  slave : the reverse direction
interface tim_cfg_seq_if;
  logic        timx_psel;
  logic        timx_penable;
  logic        timx_pwrite;
  logic [15:0] timx_paddr;
  logic [31:0] timx_pwdata;
  logic [31:0] timx_prdata;

  modport master (
    output timx_psel, timx_penable, timx_pwrite, timx_paddr, timx_pwdata,
    input  timx_prdata
  );

  modport slave (
    input  timx_psel, timx_penable, timx_pwrite, timx_paddr, timx_pwdata,
    output timx_prdata
  );
endinterface

// File: rtl/tim_cfg_seq.sv
// Table-driven APB master that programs and supervises the timer.
// Entries {op, addr, data} are fetched from a 1-cycle-latency table and executed in order:
// 00 END, 01 WRITE, 10 POLL (until (prdata & data) == data), 11 DELAY data[15:0] cycles.
// Ports:
//  apb_clk, apb_rst_n       clock, asynchronous active-low reset
//  seq_start/abort/base     run control; base sampled with start
//  tbl_rd/tbl_addr/tbl_data table read port, data valid the cycle after tbl_rd
//  timx                     APB master port (interface)
//  seq_busy/done/err        status; err_code 1=timeout 2=overrun 3=abort
//  seq_idx                  index of the current or last entry
module tim_cfg_seq #(
  parameter int unsigned TBL_AW   = 5,
  parameter int unsigned POLL_MAX = 16,
  parameter int unsigned POLL_GAP = 8
) (
  input  logic              apb_clk,
  input  logic              apb_rst_n,
  input  logic              seq_start,
  input  logic              seq_abort,
  input  logic [TBL_AW-1:0] seq_base,
  output logic              tbl_rd,
  output logic [TBL_AW-1:0] tbl_addr,
  input  logic [49:0]       tbl_data,
  tim_cfg_seq_if.master     timx,
  output logic              seq_busy,
  output logic              seq_done,
  output logic              seq_err,
  output logic [1:0]        seq_err_code,
  output logic [TBL_AW-1:0] seq_idx
);

  localparam logic [1:0] OpEnd   = 2'b00;
  localparam logic [1:0] OpWrite = 2'b01;
  localparam logic [1:0] OpPoll  = 2'b10;
  localparam logic [1:0] OpDelay = 2'b11;

  localparam logic [1:0] ErrTimeout = 2'd1;
  localparam logic [1:0] ErrOverrun = 2'd2;
  localparam logic [1:0] ErrAbort   = 2'd3;

  localparam logic [TBL_AW-1:0] IdxLast   = {TBL_AW{1'b1}};
  localparam logic [7:0]        ReadsLast = 8'(POLL_MAX - 1);
  localparam logic [15:0]       GapInit   = 16'(POLL_GAP);

  typedef enum logic [2:0] {
    StIdle, StFetch, StDecode, StSetup, StAccess, StPwait, StDly, StDone
  } state_e;

  state_e            state_q, state_d;
  logic [TBL_AW-1:0] idx_q, idx_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [7:0]        reads_q, reads_d;
  logic              abort_pend_q, abort_pend_d;
  logic              err_q, err_d;
  logic [1:0]        err_code_q, err_code_d;
  logic [1:0]        op_q;
  logic [31:0]       data_q;
  logic              psel_q, penable_q, pwrite_q;
  logic [15:0]       paddr_q;
  logic [31:0]       pwdata_q;

  logic [1:0] tbl_op;
  logic [1:0] op_next;
  logic       poll_hit;
  logic       entry_done;
  logic       fail;
  logic [1:0] fail_code;
  logic       apb_next;

  assign tbl_op   = tbl_data[49:48];
  assign poll_hit = (timx.timx_prdata & data_q) == data_q;
  // In DECODE the entry is still on tbl_data; afterwards it lives in op_q.
  assign op_next  = (state_q == StDecode) ? tbl_op : op_q;

  // State register
  always_ff @(posedge apb_clk or negedge apb_rst_n) begin
    if (!apb_rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    reads_d      = reads_q;
    abort_pend_d = abort_pend_q;
    err_d        = 1'b0;
    err_code_d   = err_code_q;
    entry_done   = 1'b0;
    fail         = 1'b0;
    fail_code    = ErrAbort;

    case (state_q)
      StIdle: begin
        if (seq_start && !seq_abort) begin
          state_d      = StFetch;
          idx_d        = seq_base;
          err_code_d   = 2'd0;
          abort_pend_d = 1'b0;
        end
      end
      StFetch: begin
        if (seq_abort) fail = 1'b1;
        else           state_d = StDecode;
      end
      StDecode: begin
        if (seq_abort) begin
          fail = 1'b1;
        end else begin
          case (tbl_op)
            OpEnd: state_d = StDone;
            OpWrite, OpPoll: begin
              state_d = StSetup;
              reads_d = 8'd0;
            end
            OpDelay: begin
              if (tbl_data[15:0] == 16'd0) begin
                entry_done = 1'b1;
              end else begin
                state_d = StDly;
                cnt_d   = tbl_data[15:0];
              end
            end
          endcase
        end
      end
      StSetup: begin
        // A started transfer always finishes; the abort is acted on after ACCESS.
        state_d = StAccess;
        if (seq_abort) abort_pend_d = 1'b1;
      end
      StAccess: begin
        if (seq_abort || abort_pend_q) begin
          fail = 1'b1;
        end else if (op_q == OpWrite || poll_hit) begin
          entry_done = 1'b1;
        end else if (reads_q == ReadsLast) begin
          fail      = 1'b1;
          fail_code = ErrTimeout;
        end else begin
          reads_d = reads_q + 8'd1;
          cnt_d   = GapInit;
          state_d = StPwait;
        end
      end
      StPwait: begin
        if (seq_abort)            fail = 1'b1;
        else if (cnt_q == 16'd1)  state_d = StSetup;
        else                      cnt_d = cnt_q - 16'd1;
      end
      StDly: begin
        if (seq_abort)            fail = 1'b1;
        else if (cnt_q == 16'd1)  entry_done = 1'b1;
        else                      cnt_d = cnt_q - 16'd1;
      end
      StDone: begin
        if (seq_abort) fail = 1'b1;
        else           state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // The last table slot must hold END; anything else completing there is an overrun.
    if (entry_done) begin
      if (idx_q == IdxLast) begin
        fail      = 1'b1;
        fail_code = ErrOverrun;
      end else begin
        idx_d   = idx_q + 1'b1;
        state_d = StFetch;
      end
    end

    if (fail) begin
      state_d    = StIdle;
      err_d      = 1'b1;
      err_code_d = fail_code;
    end
  end

  assign apb_next = (state_d == StSetup) || (state_d == StAccess);

  // Datapath and registered APB outputs
  always_ff @(posedge apb_clk or negedge apb_rst_n) begin
    if (!apb_rst_n) begin
      idx_q        <= '0;
      cnt_q        <= 16'd0;
      reads_q      <= 8'd0;
      abort_pend_q <= 1'b0;
      err_q        <= 1'b0;
      err_code_q   <= 2'd0;
      op_q         <= OpEnd;
      data_q       <= 32'd0;
      psel_q       <= 1'b0;
      penable_q    <= 1'b0;
      pwrite_q     <= 1'b0;
      paddr_q      <= 16'd0;
      pwdata_q     <= 32'd0;
    end else begin
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      reads_q      <= reads_d;
      abort_pend_q <= abort_pend_d;
      err_q        <= err_d;
      err_code_q   <= err_code_d;
      psel_q       <= apb_next;
      penable_q    <= (state_d == StAccess);
      pwrite_q     <= apb_next && (op_next == OpWrite);
      if (state_q == StDecode) begin
        op_q   <= tbl_op;
        data_q <= tbl_data[31:0];
        if (state_d == StSetup) begin
          paddr_q <= tbl_data[47:32];
          if (tbl_op == OpWrite) pwdata_q <= tbl_data[31:0];
        end
      end
    end
  end

  // Outputs
  always_comb begin
    tbl_rd       = (state_q == StFetch);
    tbl_addr     = idx_q;
    seq_busy     = (state_q != StIdle);
    seq_done     = (state_q == StDone) && !seq_abort;
    seq_err      = err_q;
    seq_err_code = err_code_q;
    seq_idx      = idx_q;
  end

  assign timx.timx_psel    = psel_q;
  assign timx.timx_penable = penable_q;
  assign timx.timx_pwrite  = pwrite_q;
  assign timx.timx_paddr   = paddr_q;
  assign timx.timx_pwdata  = pwdata_q;

endmodule

// File: tb/tb_tim_cfg_seq.sv
// Bench for tim_cfg_seq: directed table vectors, randomized tables against a cycle-count
// reference model, and hand sequences for abort, start/abort in idle and reset mid-transfer.
module tb_tim_cfg_seq;
  localparam int PMAX = 4;
  localparam int PGAP = 8;
  localparam logic [1:0] OP_END = 2'b00, OP_WR = 2'b01, OP_POLL = 2'b10, OP_DLY = 2'b11;

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [31:0] data;
    int          r;
  } txn_t;

  typedef struct {
    string            name;
    int               base;
    int               n;
    logic [7:0][49:0] ent;
    int               fall_after;
    logic [31:0]      st_hi;
    int               exp_code;
    int               exp_idx;
    int               exp_end_r;
    int               exp_nwr;
    int               exp_nrd;
  } vec_t;

  logic        apb_clk = 1'b0;
  logic        apb_rst_n = 1'b0;
  logic        seq_start = 1'b0;
  logic        seq_abort = 1'b0;
  logic [4:0]  seq_base = 5'd0;
  logic        tbl_rd;
  logic [4:0]  tbl_addr;
  logic [49:0] tbl_data = 50'd0;
  logic        seq_busy, seq_done, seq_err;
  logic [1:0]  seq_err_code;
  logic [4:0]  seq_idx;

  logic [49:0] tbl [32];
  int          cyc = 0;
  int          start_cyc = 0;
  int          r_now;
  int          reads_seen = 0;
  int          fall_cur = 0;
  logic [31:0] st_hi_cur = 32'd0;
  int          done_r, err_r;
  txn_t        mon_q[$];
  txn_t        exp_q[$];
  int          exp_code, exp_idx, exp_end_r;
  int          total = 0;
  int          bad = 0;
  vec_t        vecs [6];

  tim_cfg_seq_if bus ();

  tim_cfg_seq #(.TBL_AW(5), .POLL_MAX(PMAX), .POLL_GAP(PGAP)) dut (
    .apb_clk      (apb_clk),
    .apb_rst_n    (apb_rst_n),
    .seq_start    (seq_start),
    .seq_abort    (seq_abort),
    .seq_base     (seq_base),
    .tbl_rd       (tbl_rd),
    .tbl_addr     (tbl_addr),
    .tbl_data     (tbl_data),
    .timx         (bus),
    .seq_busy     (seq_busy),
    .seq_done     (seq_done),
    .seq_err      (seq_err),
    .seq_err_code (seq_err_code),
    .seq_idx      (seq_idx)
  );

  always #5 apb_clk = ~apb_clk;
  always @(posedge apb_clk) cyc <= cyc + 1;
  always @(posedge apb_clk) if (tbl_rd) tbl_data <= tbl[tbl_addr];

  // Status register: the watched bits appear once more than fall_cur reads have been seen.
  assign bus.timx_prdata = (reads_seen > fall_cur) ? st_hi_cur : 32'h0;

  function automatic logic [49:0] mk(input logic [1:0] op, input logic [15:0] a,
                                     input logic [31:0] d);
    return {op, a, d};
  endfunction

  task automatic chk(input string what, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", what, got, want);
    end
  endtask

  function automatic int count_kind(input logic wr);
    int c = 0;
    foreach (mon_q[i]) if (mon_q[i].wr == wr) c++;
    return c;
  endfunction

  // One cycle: advance to the falling edge and record what the DUT shows there.
  task automatic step();
    @(negedge apb_clk);
    r_now = cyc - start_cyc;
    if (bus.timx_psel && bus.timx_penable) begin
      mon_q.push_back('{bus.timx_pwrite, bus.timx_paddr,
                        bus.timx_pwrite ? bus.timx_pwdata : 32'h0, r_now});
      if (!bus.timx_pwrite) reads_seen++;
    end
    if (seq_done && done_r < 0) done_r = r_now;
    if (seq_err && err_r < 0) err_r = r_now;
  endtask

  task automatic begin_run(input int base);
    mon_q.delete();
    reads_seen = 0;
    done_r     = -1;
    err_r      = -1;
    seq_base   = 5'(base);
    seq_start  = 1'b1;
    start_cyc  = cyc + 1;
  endtask

  // Reference: walk the table with the per-op cycle costs (2 to fetch/decode, 2 per APB
  // transfer, POLL_GAP between polls, N for a delay). r=0 is the first cycle after start.
  task automatic model_run(input int base, input int fa, input logic [31:0] sh);
    int t = 0, idx = base, reads = 0, guard = 0;
    bit fin = 0;
    logic [1:0] op;
    logic [15:0] a;
    logic [31:0] d, st;
    exp_q.delete();
    while (!fin && guard < 64) begin
      guard++;
      {op, a, d} = tbl[idx];
      t += 2;
      if (op == OP_END) begin
        exp_code = 0; exp_end_r = t; exp_idx = idx; fin = 1;
      end else begin
        if (op == OP_WR) begin
          exp_q.push_back('{1'b1, a, d, t + 1});
          t += 2;
        end else if (op == OP_POLL) begin
          for (int k = 1; k <= PMAX; k++) begin
            reads++;
            exp_q.push_back('{1'b0, a, 32'h0, t + 1});
            t += 2;
            st = (reads > fa) ? sh : 32'h0;
            if ((st & d) == d) break;
            if (k == PMAX) begin
              exp_code = 1; exp_end_r = t; exp_idx = idx; fin = 1;
              break;
            end
            t += PGAP;
          end
        end else begin
          t += int'(d[15:0]);
        end
        if (!fin) begin
          if (idx == 31) begin
            exp_code = 2; exp_end_r = t; exp_idx = idx; fin = 1;
          end else begin
            idx++;
          end
        end
      end
    end
  endtask

  task automatic run_check(input string nm, input int base, input int fa, input logic [31:0] sh,
                           input bit extra);
    int n = 0;
    int lim;
    fall_cur  = fa;
    st_hi_cur = sh;
    model_run(base, fa, sh);
    step();
    begin_run(base);
    while (done_r < 0 && err_r < 0 && n < 3000) begin
      step();
      seq_start = 1'b0;
      // A second start while busy must be ignored.
      if (extra && exp_end_r > 8 && r_now == 4) begin
        seq_start = 1'b1;
        seq_base  = 5'(base ^ 5);
      end
      n++;
    end
    seq_start = 1'b0;
    chk({nm, " finished"}, 64'(n < 3000), 64'd1);
    step();
    chk({nm, " busy after"}, 64'(seq_busy), 64'd0);
    chk({nm, " done cycle"}, 64'(done_r), 64'(exp_code == 0 ? exp_end_r : -1));
    chk({nm, " err cycle"}, 64'(err_r), 64'(exp_code != 0 ? exp_end_r : -1));
    chk({nm, " err code"}, 64'(seq_err_code), 64'(exp_code));
    chk({nm, " idx"}, 64'(seq_idx), 64'(exp_idx));
    chk({nm, " txn count"}, 64'(mon_q.size()), 64'(exp_q.size()));
    lim = (mon_q.size() < exp_q.size()) ? mon_q.size() : exp_q.size();
    for (int i = 0; i < lim; i++) begin
      chk($sformatf("%s txn%0d kind/addr/data", nm, i),
          64'({mon_q[i].wr, mon_q[i].addr, mon_q[i].data}),
          64'({exp_q[i].wr, exp_q[i].addr, exp_q[i].data}));
      chk($sformatf("%s txn%0d cycle", nm, i), 64'(mon_q[i].r), 64'(exp_q[i].r));
    end
  endtask

  task automatic run_vec(input int i);
    for (int j = 0; j < 32; j++) tbl[j] = 50'h0;
    for (int j = 0; j < vecs[i].n; j++) tbl[vecs[i].base + j] = vecs[i].ent[j];
    run_check(vecs[i].name, vecs[i].base, vecs[i].fall_after, vecs[i].st_hi, 1'b0);
    chk({vecs[i].name, " vec code"}, 64'(seq_err_code), 64'(vecs[i].exp_code));
    chk({vecs[i].name, " vec idx"}, 64'(seq_idx), 64'(vecs[i].exp_idx));
    chk({vecs[i].name, " vec end"}, 64'(done_r >= 0 ? done_r : err_r), 64'(vecs[i].exp_end_r));
    chk({vecs[i].name, " vec writes"}, 64'(count_kind(1'b1)), 64'(vecs[i].exp_nwr));
    chk({vecs[i].name, " vec reads"}, 64'(count_kind(1'b0)), 64'(vecs[i].exp_nrd));
  endtask

  initial begin
    int n, base, ne, sel;
    logic [31:0] sh, mask;

    vecs[0] = '{"t1_bringup", 0, 6, '0, 0, 32'h0, 0, 5, 22, 5, 0};
    vecs[0].ent[0] = mk(OP_WR, 16'h002C, 32'd36);
    vecs[0].ent[1] = mk(OP_WR, 16'h0018, 32'd100);
    vecs[0].ent[2] = mk(OP_WR, 16'h0008, 32'd66);
    vecs[0].ent[3] = mk(OP_WR, 16'h000C, 32'd40);
    vecs[0].ent[4] = mk(OP_WR, 16'h0000, 32'd1);
    vecs[0].ent[5] = mk(OP_END, 16'h0, 32'h0);
    vecs[1] = '{"t2_poll", 0, 3, '0, 3, 32'h40, 0, 2, 40, 1, 4};
    vecs[1].ent[0] = mk(OP_WR, 16'h000C, 32'd40);
    vecs[1].ent[1] = mk(OP_POLL, 16'h0010, 32'h40);
    vecs[1].ent[2] = mk(OP_END, 16'h0, 32'h0);
    vecs[2] = '{"t3_timeout", 0, 2, '0, 0, 32'h40, 1, 0, 34, 0, 4};
    vecs[2].ent[0] = mk(OP_POLL, 16'h0010, 32'h8000_0000);
    vecs[2].ent[1] = mk(OP_END, 16'h0, 32'h0);
    vecs[3] = '{"t4_overrun", 28, 4, '0, 0, 32'h0, 2, 31, 24, 3, 0};
    vecs[3].ent[0] = mk(OP_DLY, 16'h0, 32'd10);
    vecs[3].ent[1] = mk(OP_WR, 16'h0004, 32'd1);
    vecs[3].ent[2] = mk(OP_WR, 16'h0008, 32'd2);
    vecs[3].ent[3] = mk(OP_WR, 16'h000C, 32'd3);
    vecs[4] = '{"dly_zero", 0, 3, '0, 0, 32'h0, 0, 2, 8, 1, 0};
    vecs[4].ent[0] = mk(OP_DLY, 16'h0, 32'hABCD_0000);
    vecs[4].ent[1] = mk(OP_WR, 16'h0004, 32'd7);
    vecs[4].ent[2] = mk(OP_END, 16'h0, 32'h0);
    vecs[5] = '{"end_last", 31, 1, '0, 0, 32'h0, 0, 31, 2, 0, 0};
    vecs[5].ent[0] = mk(OP_END, 16'h0, 32'h0);

    done_r = -1;
    err_r  = -1;

    // Reset state
    step();
    step();
    chk("reset apb ctl", 64'({bus.timx_psel, bus.timx_penable, bus.timx_pwrite}), 64'd0);
    chk("reset apb bus", 64'({bus.timx_paddr, bus.timx_pwdata}), 64'd0);
    chk("reset tbl", 64'({tbl_rd, tbl_addr}), 64'd0);
    chk("reset status", 64'({seq_busy, seq_done, seq_err, seq_err_code, seq_idx}), 64'd0);
    apb_rst_n = 1'b1;

    for (int i = 0; i < 6; i++) run_vec(i);

    // Random tables against the model
    for (int it = 0; it < 40; it++) begin
      for (int j = 0; j < 32; j++) tbl[j] = 50'h0;
      base = $urandom_range(0, 31);
      ne   = $urandom_range(1, 5);
      sh   = $urandom;
      for (int j = 0; j < ne && base + j < 32; j++) begin
        sel = $urandom_range(0, 2);
        if (sel == 0) begin
          tbl[base + j] = mk(OP_WR, 16'($urandom), $urandom);
        end else if (sel == 1) begin
          case ($urandom_range(0, 2))
            0:       mask = sh & $urandom;
            1:       mask = ~sh & $urandom;
            default: mask = 32'h0;
          endcase
          tbl[base + j] = mk(OP_POLL, 16'h0010, mask);
        end else begin
          tbl[base + j] = mk(OP_DLY, 16'($urandom),
                             {16'($urandom), 16'($urandom_range(0, 12))});
        end
      end
      run_check($sformatf("rnd%0d", it), base, $urandom_range(0, 5), sh,
                $urandom_range(0, 1) == 1);
    end

    // Abort during SETUP of the second write
    for (int j = 0; j < 32; j++) tbl[j] = 50'h0;
    for (int j = 0; j < vecs[0].n; j++) tbl[j] = vecs[0].ent[j];
    step();
    begin_run(0);
    step();
    seq_start = 1'b0;
    n = 0;
    while (!(bus.timx_psel && !bus.timx_penable && count_kind(1'b1) == 1) && n < 100) begin
      step();
      n++;
    end
    chk("t5 reached setup", 64'(n < 100), 64'd1);
    seq_abort = 1'b1;
    step();
    chk("t5 access completes", 64'({bus.timx_psel, bus.timx_penable, bus.timx_pwrite}), 64'h7);
    seq_abort = 1'b0;
    step();
    chk("t5 busy low", 64'(seq_busy), 64'd0);
    chk("t5 err pulse", 64'(seq_err), 64'd1);
    chk("t5 err code", 64'(seq_err_code), 64'd3);
    repeat (30) step();
    chk("t5 write count", 64'(count_kind(1'b1)), 64'd2);
    chk("t5 second addr", 64'(mon_q.size() > 1 ? mon_q[1].addr : 16'hFFFF), 64'h0018);
    chk("t5 no done", 64'(done_r), 64'(-1));

    // Start together with abort in idle: nothing happens, code is kept
    seq_abort = 1'b1;
    seq_start = 1'b1;
    seq_base  = 5'd3;
    step();
    seq_abort = 1'b0;
    seq_start = 1'b0;
    step();
    chk("idle abort+start busy", 64'({seq_busy, tbl_rd}), 64'd0);
    chk("idle abort+start code", 64'(seq_err_code), 64'd3);

    // Reset in the middle of an ACCESS
    begin_run(0);
    step();
    seq_start = 1'b0;
    n = 0;
    while (!(bus.timx_psel && bus.timx_penable) && n < 100) begin
      step();
      n++;
    end
    chk("t6 reached access", 64'(n < 100), 64'd1);
    #1 apb_rst_n = 1'b0;
    #1;
    chk("t6 apb drop", 64'({bus.timx_psel, bus.timx_penable, bus.timx_pwrite}), 64'd0);
    chk("t6 status drop", 64'({seq_busy, seq_err_code, seq_idx}), 64'd0);
    step();
    apb_rst_n = 1'b1;
    run_vec(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
